// File: rtl/board_pkg.sv
// Shared board-storage types: cell encoding, board geometry, requester ids and arbiter states.
package board_pkg;

  localparam int unsigned BOARD_COLS = 10;
  localparam int unsigned BOARD_ROWS = 10;
  localparam int unsigned CELL_W     = 2;

  typedef logic [CELL_W-1:0] cell_t;

  localparam cell_t CELL_EMPTY = 2'b00;
  localparam cell_t CELL_TRIG  = 2'b01;
  localparam cell_t CELL_CIRC  = 2'b10;

  typedef enum logic [1:0] {REQ_NONE, REQ_DISP, REQ_GAME, REQ_CHK} req_id_t;

  typedef enum logic {ST_CLEAR, ST_ARB} arb_state_t;

endpackage

// File: rtl/board_ram.sv
// Single-port board RAM: write-enable, registered read (read-before-write), no reset on contents.
module board_ram #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned WORDS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/board_mem_arbiter.sv
// Shares the board RAM between display, game FSM and win checker; sweeps the board clear
// after reset or on clr_start.
module board_mem_arbiter
  import board_pkg::*;
#(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DEPTH    = 100,
  parameter int unsigned DATA_W   = 2,
  parameter int unsigned DISP_RUN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_gnt,
  output logic [DATA_W-1:0] game_rdata,
  output logic              game_rvalid,
  input  logic              chk_req,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_gnt,
  output logic [DATA_W-1:0] chk_rdata,
  output logic              chk_rvalid,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              addr_err
);

  localparam int unsigned RUN_W = $clog2(DISP_RUN + 1);

  arb_state_t        state;
  logic [ADDR_W-1:0] sweep_addr;
  logic [RUN_W-1:0]  run_cnt;
  req_id_t           rr_ptr;
  req_id_t           rsp_id;
  logic              rsp_oob;
  logic [DATA_W-1:0] disp_hold, game_hold, chk_hold;

  req_id_t           win_c;
  logic              others_c;
  logic              run_full_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic              sel_oob_c;
  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_wdata_c;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] rd_val_c;

  // Grant selection: display first unless its run is exhausted, then game/chk round-robin.
  always_comb begin
    win_c      = REQ_NONE;
    others_c   = game_req | chk_req;
    run_full_c = run_cnt >= RUN_W'(DISP_RUN);
    if (state == ST_ARB && !clr_start) begin
      if (disp_req && !(run_full_c && others_c))            win_c = REQ_DISP;
      else if (game_req && (!chk_req || rr_ptr == REQ_GAME)) win_c = REQ_GAME;
      else if (chk_req)                                      win_c = REQ_CHK;
    end
  end

  assign disp_gnt = (win_c == REQ_DISP);
  assign game_gnt = (win_c == REQ_GAME);
  assign chk_gnt  = (win_c == REQ_CHK);

  // RAM port mux: the clear sweep owns the port while in CLEAR.
  always_comb begin
    case (win_c)
      REQ_GAME: sel_addr_c = game_addr;
      REQ_CHK:  sel_addr_c = chk_addr;
      default:  sel_addr_c = disp_addr;
    endcase
    sel_oob_c = 32'(sel_addr_c) >= DEPTH;
    if (state == ST_CLEAR) begin
      ram_we_c    = 1'b1;
      ram_addr_c  = sweep_addr;
      ram_wdata_c = DATA_W'(CELL_EMPTY);
    end else begin
      ram_we_c    = game_gnt && game_we && !sel_oob_c;
      ram_addr_c  = sel_addr_c;
      ram_wdata_c = game_wdata;
    end
  end

  board_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .addr  (ram_addr_c),
    .wdata (ram_wdata_c),
    .rdata (ram_q)
  );

  // Clear sweep / arbitration state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      sweep_addr <= '0;
      clr_busy   <= 1'b1;
      clr_done   <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (sweep_addr == ADDR_W'(DEPTH - 1)) begin
            state    <= ST_ARB;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            sweep_addr <= sweep_addr + ADDR_W'(1);
          end
        end
        ST_ARB: begin
          if (clr_start) begin
            state      <= ST_CLEAR;
            sweep_addr <= '0;
            clr_busy   <= 1'b1;
          end
        end
      endcase
    end
  end

  // Display run counter and game/chk round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
      rr_ptr  <= REQ_GAME;
    end else begin
      if (win_c == REQ_DISP)                        run_cnt <= others_c ? run_cnt + RUN_W'(1) : '0;
      else if (win_c != REQ_NONE || !others_c)      run_cnt <= '0;
      if (win_c == REQ_GAME)                        rr_ptr  <= REQ_CHK;
      else if (win_c == REQ_CHK)                    rr_ptr  <= REQ_GAME;
    end
  end

  // Response routing: remember who was granted a read and whether it was out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id    <= REQ_NONE;
      rsp_oob   <= 1'b0;
      addr_err  <= 1'b0;
      disp_hold <= '0;
      game_hold <= '0;
      chk_hold  <= '0;
    end else begin
      rsp_id   <= (win_c == REQ_GAME && game_we) ? REQ_NONE : win_c;
      rsp_oob  <= sel_oob_c;
      addr_err <= (win_c != REQ_NONE) && sel_oob_c;
      if (rsp_id == REQ_DISP) disp_hold <= rd_val_c;
      if (rsp_id == REQ_GAME) game_hold <= rd_val_c;
      if (rsp_id == REQ_CHK)  chk_hold  <= rd_val_c;
    end
  end

  assign rd_val_c    = rsp_oob ? '0 : ram_q;
  assign disp_rvalid = (rsp_id == REQ_DISP);
  assign game_rvalid = (rsp_id == REQ_GAME);
  assign chk_rvalid  = (rsp_id == REQ_CHK);
  assign disp_rdata  = disp_rvalid ? rd_val_c : disp_hold;
  assign game_rdata  = game_rvalid ? rd_val_c : game_hold;
  assign chk_rdata   = chk_rvalid  ? rd_val_c : chk_hold;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Scoreboard bench for board_mem_arbiter: directed scenarios then held-request random traffic.
module tb_board_mem_arbiter;
  import board_pkg::*;

  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DEPTH    = 100;
  localparam int unsigned DATA_W   = 2;
  localparam int unsigned DISP_RUN = 8;

  logic clk, rst_n;
  logic disp_req, disp_gnt, disp_rvalid;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rdata;
  logic game_req, game_we, game_gnt, game_rvalid;
  logic [ADDR_W-1:0] game_addr;
  logic [DATA_W-1:0] game_wdata, game_rdata;
  logic chk_req, chk_gnt, chk_rvalid;
  logic [ADDR_W-1:0] chk_addr;
  logic [DATA_W-1:0] chk_rdata;
  logic clr_start, clr_busy, clr_done, addr_err;

  board_mem_arbiter #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .DISP_RUN(DISP_RUN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .game_req(game_req), .game_we(game_we), .game_addr(game_addr),
    .game_wdata(game_wdata), .game_gnt(game_gnt), .game_rdata(game_rdata),
    .game_rvalid(game_rvalid),
    .chk_req(chk_req), .chk_addr(chk_addr), .chk_gnt(chk_gnt),
    .chk_rdata(chk_rdata), .chk_rvalid(chk_rvalid),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         stamp;
    req_id_t    id;
    logic [1:0] data;
    logic       err;
  } rsp_t;

  int         checks = 0;
  int         failures = 0;
  int         cyc_cnt = 0;
  rsp_t       exp_q[$];
  logic [1:0] model_mem [128];
  logic [1:0] last_rd [3];
  int         busy_left;
  int         run;
  req_id_t    rr;
  logic       done_next;
  rsp_t       mon_e;
  logic [2:0] mon_ev;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // One bench cycle: drive inputs, predict and compare grants, queue expected responses.
  task automatic cyc(input logic dr, input logic [6:0] da,
                     input logic gr, input logic gw, input logic [6:0] ga, input logic [1:0] gd,
                     input logic cr, input logic [6:0] ca, input logic cs,
                     output req_id_t win);
    logic       others, oob;
    logic [6:0] a;
    logic [2:0] exp_g;
    @(negedge clk);
    disp_req = dr; disp_addr = da;
    game_req = gr; game_we = gw; game_addr = ga; game_wdata = gd;
    chk_req = cr; chk_addr = ca; clr_start = cs;
    #1;
    others = gr | cr;
    win = REQ_NONE;
    check("clr_busy", 32'(clr_busy), 32'(busy_left > 0));
    check("clr_done", 32'(clr_done), 32'(done_next));
    done_next = 1'b0;
    if (busy_left > 0) begin
      busy_left--;
      done_next = (busy_left == 0);
    end else if (cs) begin
      busy_left = DEPTH;
      for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 2'b00;
    end else if (dr && !(run >= int'(DISP_RUN) && others)) win = REQ_DISP;
    else if (gr && cr) win = rr;
    else if (gr) win = REQ_GAME;
    else if (cr) win = REQ_CHK;
    exp_g = {win == REQ_DISP, win == REQ_GAME, win == REQ_CHK};
    check("gnt", 32'({disp_gnt, game_gnt, chk_gnt}), 32'(exp_g));
    if (win == REQ_DISP) run = others ? run + 1 : 0;
    else if (win != REQ_NONE || !others) run = 0;
    if (win == REQ_GAME) rr = REQ_CHK;
    else if (win == REQ_CHK) rr = REQ_GAME;
    if (win != REQ_NONE) begin
      a = (win == REQ_DISP) ? da : (win == REQ_GAME) ? ga : ca;
      oob = 32'(a) >= DEPTH;
      if (win == REQ_GAME && gw) begin
        if (!oob) model_mem[a] = gd;
        else exp_q.push_back('{cyc_cnt + 1, REQ_NONE, 2'b00, 1'b1});
      end else begin
        exp_q.push_back('{cyc_cnt + 1, win, oob ? 2'b00 : model_mem[a], oob});
      end
    end
  endtask

  // Response monitor: pops the scoreboard whenever a response is due and checks held rdata.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].stamp == cyc_cnt) begin
        mon_e  = exp_q.pop_front();
        mon_ev = {mon_e.id == REQ_DISP, mon_e.id == REQ_GAME, mon_e.id == REQ_CHK};
        check("rvalid", 32'({disp_rvalid, game_rvalid, chk_rvalid}), 32'(mon_ev));
        check("addr_err", 32'(addr_err), 32'(mon_e.err));
        if (mon_e.id == REQ_DISP) last_rd[0] = mon_e.data;
        if (mon_e.id == REQ_GAME) last_rd[1] = mon_e.data;
        if (mon_e.id == REQ_CHK)  last_rd[2] = mon_e.data;
      end else begin
        check("idle_rsp", 32'({disp_rvalid, game_rvalid, chk_rvalid, addr_err}), 32'(0));
      end
      check("disp_rdata", 32'(disp_rdata), 32'(last_rd[0]));
      check("game_rdata", 32'(game_rdata), 32'(last_rd[1]));
      check("chk_rdata",  32'(chk_rdata),  32'(last_rd[2]));
    end
  end

  function automatic logic [6:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return 7'($urandom_range(100, 127));
    return 7'($urandom_range(0, 99));
  endfunction

  initial begin
    req_id_t    w;
    logic       g, pd, pg, pgw, pc, cs;
    logic [6:0] pda, pga, pca;
    logic [1:0] pgd;

    for (int i = 0; i < 128; i++) model_mem[i] = 2'b00;
    for (int i = 0; i < 3; i++) last_rd[i] = 2'b00;
    busy_left = DEPTH; run = 0; rr = REQ_GAME; done_next = 1'b0;

    rst_n = 1'b0;
    disp_req = 1'b1; disp_addr = 7'd3; game_req = 1'b1; game_we = 1'b1;
    game_addr = 7'd4; game_wdata = 2'b01; chk_req = 1'b1; chk_addr = 7'd5; clr_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'({disp_gnt, game_gnt, chk_gnt}), 32'(0));
    check("rst_rvalid", 32'({disp_rvalid, game_rvalid, chk_rvalid}), 32'(0));
    check("rst_rdata", 32'({disp_rdata, game_rdata, chk_rdata}), 32'(0));
    check("rst_done_err", 32'({clr_done, addr_err}), 32'(0));
    disp_req = 1'b0; game_req = 1'b0; chk_req = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Power-up sweep, then reads of swept cells.
    repeat (101) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, w);
    cyc(1, 7'd0,  0, 0, 0, 0, 0, 0, 0, w);
    cyc(1, 7'd57, 0, 0, 0, 0, 0, 0, 0, w);
    cyc(1, 7'd99, 0, 0, 0, 0, 0, 0, 0, w);
    // Write then immediate read by another requester.
    cyc(0, 0, 1, 1, 7'd34, 2'b01, 0, 0, 0, w);
    cyc(0, 0, 0, 0, 0, 0, 1, 7'd34, 0, w);
    // Display streaming while game waits.
    g = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cyc(1, 7'($urandom_range(0, 99)), g, 0, 7'd34, 0, 0, 0, 0, w);
      if (w == REQ_GAME) g = 1'b0;
    end
    // Game and chk contend.
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 7'd34, 0, 1, 7'd20, 0, w);
    // Out-of-range write and read.
    cyc(0, 0, 1, 1, 7'd105, 2'b10, 0, 0, 0, w);
    cyc(0, 0, 1, 0, 7'd105, 0, 0, 0, 0, w);
    // Clear while a read is in flight, with a second clr_start mid-sweep.
    cyc(0, 0, 1, 1, 7'd50, 2'b10, 0, 0, 0, w);
    cyc(0, 0, 0, 0, 0, 0, 1, 7'd50, 0, w);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, w);
    repeat (40) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, w);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, w);
    repeat (62) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, w);
    cyc(1, 7'd34, 0, 0, 0, 0, 1, 7'd50, 0, w);
    cyc(0, 0, 0, 0, 0, 0, 1, 7'd50, 0, w);

    // Random traffic; each requester holds its request until granted.
    pd = 1'b0; pg = 1'b0; pc = 1'b0;
    pda = '0; pga = '0; pca = '0; pgw = 1'b0; pgd = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pd) begin pd = ($urandom_range(0, 2) != 0); pda = rand_addr(); end
      if (!pg) begin
        pg = ($urandom_range(0, 2) == 0); pga = rand_addr();
        pgw = $urandom_range(0, 1) == 1; pgd = 2'($urandom_range(0, 3));
      end
      if (!pc) begin pc = ($urandom_range(0, 2) == 0); pca = rand_addr(); end
      cs = ($urandom_range(0, 199) == 0);
      cyc(pd, pda, pg, pgw, pga, pgd, pc, pca, cs, w);
      if (w == REQ_DISP) pd = 1'b0;
      if (w == REQ_GAME) pg = 1'b0;
      if (w == REQ_CHK)  pc = 1'b0;
    end
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, w);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
